// File: rtl/sprite_draw_engine.sv
// ---------------------------------------------------------------------------
// sprite_draw_engine
//
// Purpose:
//   Executes the CHIP-8 DXYN draw. An N-row, 8-pixel-wide sprite is read from
//   RAM starting at I and XORed into the 64x32 1-bpp framebuffer. The
//   framebuffer is 256 bytes at FB_BASE, 8 bytes per row, and the MSB of each
//   byte is the leftmost pixel. Each sprite row touches one framebuffer byte
//   (aligned x) or two neighbouring bytes (unaligned x). Every byte is
//   read-modify-written. A pixel that was set and is now cleared raises
//   collision.
//
// Optional feature (compile-time macro SPRITE_CLIP_EN):
//   Defined   : the start coordinate still wraps. Pixels past the right edge
//               are dropped, so the right byte is skipped when cb == 7.
//               Drawing ends at the first row that would fall below row 31.
//   Undefined : full wrap-around, both horizontally and vertically.
//
// Ports:
//   clk, reset         system clock; synchronous active-high reset
//   draw               start request, sampled only while idle
//   address[15:0]      sprite base I; only [ADDR_W-1:0] is used
//   sprite_height[3:0] number of sprite rows N (0..15)
//   x[7:0], y[7:0]     start column (mod 64) and start row (mod 32)
//   busy               high while the FSM is not in IDLE
//   collision          result of the last draw; held until the next start
//   mem_read_*         RAM read port; data returns one cycle after the address
//   mem_write_*        RAM write port; single-cycle write strobe
//   dbg_state[2:0]     current FSM state, for observation
//
// Memory handshake: the read and write ports have no ready/valid
// back-pressure. mem_read_enable qualifies mem_read_address in the cycle it is
// high, and mem_read_data is valid in the following cycle. mem_write_enable
// commits mem_write_data to mem_write_address at the end of the cycle it is
// high. The two enables are never high in the same cycle.
// ---------------------------------------------------------------------------
module sprite_draw_engine #(
  parameter int                ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] FB_BASE = 12'h100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              draw,
  input  logic [15:0]       address,
  input  logic [3:0]        sprite_height,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  output logic              busy,
  output logic              collision,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [7:0]        mem_read_data,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [7:0]        mem_write_data,
  output logic              mem_write_enable,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_SPR = 3'd1,
    S_LATCH_SPR = 3'd2,
    S_READ_L    = 3'd3,
    S_WRITE_L   = 3'd4,
    S_READ_R    = 3'd5,
    S_WRITE_R   = 3'd6,
    S_FINISH    = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;       // sprite base address I
  logic [3:0]        n_q, n_d;             // sprite height
  logic [5:0]        x0_q, x0_d;           // start column, already mod 64
  logic [4:0]        y0_q, y0_d;           // start row, already mod 32
  logic [3:0]        r_q, r_d;             // current sprite row
  logic [7:0]        pl_q, pl_d;           // pattern for the left byte
  logic [7:0]        pr_q, pr_d;           // pattern for the right byte
  logic              collision_q, collision_d;

  // Only the low address bits and the coordinate bits that survive the
  // modulo are used. The rest is folded here so it is visibly intentional.
  logic unused_inputs;
  assign unused_inputs = ^{address[15:ADDR_W], x[7:6], y[7:5]};

  // -------------------------------------------------------------------------
  // Address and pattern arithmetic
  // -------------------------------------------------------------------------
  logic [2:0]        cb;        // column byte of the left byte
  logic [2:0]        sh;        // pixel shift inside the byte
  logic [4:0]        fb_row;    // framebuffer row; the 5-bit add wraps mod 32
  logic [ADDR_W-1:0] addr_l;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       shifted;
  logic              last_row;
  logic              need_r;
  logic              end_draw;

  assign cb      = x0_q[5:3];
  assign sh      = x0_q[2:0];
  assign fb_row  = y0_q + 5'(r_q);
  assign addr_l  = FB_BASE + ADDR_W'({fb_row, cb});
  // cb + 1 is 3 bits wide, so the right byte wraps to column byte 0 of the
  // same row.
  assign addr_r  = FB_BASE + ADDR_W'({fb_row, 3'(cb + 3'd1)});

  // A single 16-bit shift yields both halves. The upper byte is s >> sh and
  // the lower byte is s << (8 - sh). The lower byte is all zeros when sh == 0.
  assign shifted = {mem_read_data, 8'h00} >> sh;

  assign last_row = (4'(r_q + 4'd1) == n_q);

`ifdef SPRITE_CLIP_EN
  logic off_bottom;
  // The next row would land at y0 + r + 1. Anything at or past 32 is clipped.
  assign off_bottom = ({1'b0, y0_q} + {2'b00, r_q} + 6'd1) >= 6'd32;
  assign need_r     = (sh != 3'd0) && (cb != 3'd7);
  assign end_draw   = last_row || off_bottom;
`else
  assign need_r     = (sh != 3'd0);
  assign end_draw   = last_row;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      n_q         <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      r_q         <= '0;
      pl_q        <= '0;
      pr_q        <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      n_q         <= n_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      r_q         <= r_d;
      pl_q        <= pl_d;
      pr_q        <= pr_d;
      collision_q <= collision_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    n_d               = n_q;
    x0_d              = x0_q;
    y0_d              = y0_q;
    r_d               = r_q;
    pl_d              = pl_q;
    pr_d              = pr_q;
    collision_d       = collision_q;
    mem_read_address  = '0;
    mem_read_enable   = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_write_enable  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (draw) begin
          base_d      = address[ADDR_W-1:0];
          n_d         = sprite_height;
          x0_d        = x[5:0];
          y0_d        = y[4:0];
          r_d         = 4'd0;
          collision_d = 1'b0;
          state_d     = (sprite_height == 4'd0) ? S_FINISH : S_FETCH_SPR;
        end
      end

      S_FETCH_SPR: begin
        mem_read_address = base_q + ADDR_W'(r_q);
        mem_read_enable  = 1'b1;
        state_d          = S_LATCH_SPR;
      end

      S_LATCH_SPR: begin
        pl_d    = shifted[15:8];
        pr_d    = shifted[7:0];
        state_d = S_READ_L;
      end

      S_READ_L: begin
        mem_read_address = addr_l;
        mem_read_enable  = 1'b1;
        state_d          = S_WRITE_L;
      end

      S_WRITE_L: begin
        mem_write_address = addr_l;
        mem_write_data    = mem_read_data ^ pl_q;
        mem_write_enable  = 1'b1;
        collision_d       = collision_q | (|(mem_read_data & pl_q));
        if (need_r) begin
          state_d = S_READ_R;
        end else if (end_draw) begin
          state_d = S_FINISH;
        end else begin
          r_d     = r_q + 4'd1;
          state_d = S_FETCH_SPR;
        end
      end

      S_READ_R: begin
        mem_read_address = addr_r;
        mem_read_enable  = 1'b1;
        state_d          = S_WRITE_R;
      end

      S_WRITE_R: begin
        mem_write_address = addr_r;
        mem_write_data    = mem_read_data ^ pr_q;
        mem_write_enable  = 1'b1;
        collision_d       = collision_q | (|(mem_read_data & pr_q));
        if (end_draw) begin
          state_d = S_FINISH;
        end else begin
          r_d     = r_q + 4'd1;
          state_d = S_FETCH_SPR;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign collision = collision_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// ---------------------------------------------------------------------------
// tb_sprite_draw_engine
//
// Directed bench for sprite_draw_engine. A 4 KiB byte RAM model answers the
// read port with one cycle of latency. Every write strobe is checked against
// an expected queue of {address, data} entries that each scenario task fills
// with hand-computed values.
// ---------------------------------------------------------------------------
module tb_sprite_draw_engine;

  // -------------------------------------------------------------------------
  // Clock and reset
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        draw = 1'b0;
  logic [15:0] address = '0;
  logic [3:0]  sprite_height = '0;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic        busy;
  logic        collision;
  logic [11:0] mem_read_address;
  logic [7:0]  mem_read_data = '0;
  logic        mem_read_enable;
  logic [11:0] mem_write_address;
  logic [7:0]  mem_write_data;
  logic        mem_write_enable;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  sprite_draw_engine #(.ADDR_W(12), .FB_BASE(12'h100)) dut (
    .clk               (clk),
    .reset             (reset),
    .draw              (draw),
    .address           (address),
    .sprite_height     (sprite_height),
    .x                 (x),
    .y                 (y),
    .busy              (busy),
    .collision         (collision),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data),
    .mem_read_enable   (mem_read_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable),
    .dbg_state         (dbg_state)
  );

  // -------------------------------------------------------------------------
  // RAM model and write scoreboard
  // -------------------------------------------------------------------------
  logic [7:0]  mem [0:4095];
  logic [19:0] exp_q[$];
  logic [19:0] exp_head;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_count = 0;
  int          rw_overlap = 0;

  always @(posedge clk) begin
    if (mem_read_enable) begin
      mem_read_data <= mem[mem_read_address];
      rd_count++;
    end
    if (mem_read_enable && mem_write_enable) rw_overlap++;
    if (mem_write_enable) begin
      mem[mem_write_address] <= mem_write_data;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                 mem_write_address, mem_write_data);
      end else begin
        exp_head = exp_q.pop_front();
        if ({mem_write_address, mem_write_data} !== exp_head) begin
          n_fail++;
          $display("FAIL write_value: got addr %h data %h, required addr %h data %h",
                   mem_write_address, mem_write_data, exp_head[19:8], exp_head[7:0]);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic clear_fb();
    for (int i = 12'h100; i < 12'h200; i++) mem[i] = 8'h00;
  endtask

  // Pulses draw for one cycle, then counts the cycles in which busy is high.
  task automatic run_draw(input logic [15:0] a, input logic [3:0] n,
                          input logic [7:0] xx, input logic [7:0] yy,
                          output int cycles);
    @(negedge clk);
    address       = a;
    sprite_height = n;
    x             = xx;
    y             = yy;
    draw          = 1'b1;
    @(negedge clk);
    draw   = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL reset_collision: got %b, required 0", collision); end
    n_checks++; if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_enables: got rd %b wr %b, required 0 0", mem_read_enable, mem_write_enable); end
    n_checks++; if (mem_read_address !== 12'h000 || mem_write_address !== 12'h000 || mem_write_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_addr_data: got ra %h wa %h wd %h, required 0 0 0",
                         mem_read_address, mem_write_address, mem_write_data); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aligned();
    int cyc, rb;
    clear_fb();
    mem[12'h300] = 8'hF0;
    exp_q.push_back({12'h100, 8'hF0});
    rb = rd_count;
    run_draw(16'h0300, 4'd1, 8'd0, 8'd0, cyc);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL aligned_busy: got %0d cycles, required 5", cyc); end
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL aligned_coll: got %b, required 0", collision); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL aligned_writes: got %0d missing, required 0", exp_q.size()); exp_q.delete(); end
    n_checks++; if (rd_count - rb != 2) begin n_fail++; $display("FAIL aligned_reads: got %0d, required 2", rd_count - rb); end
  endtask

  task automatic test_collision();
    int cyc;
    exp_q.push_back({12'h100, 8'h00});
    run_draw(16'h0300, 4'd1, 8'd0, 8'd0, cyc);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL coll_busy: got %0d cycles, required 5", cyc); end
    n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL coll_flag: got %b, required 1", collision); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL coll_writes: got %0d missing, required 0", exp_q.size()); exp_q.delete(); end
    repeat (4) @(negedge clk);
    n_checks++; if (collision !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL coll_hold: got coll %b busy %b, required 1 0", collision, busy); end
  endtask

  task automatic test_unaligned();
    int cyc, rb;
    clear_fb();
    mem[12'h300] = 8'hFF;
    exp_q.push_back({12'h108, 8'h1F});
    exp_q.push_back({12'h109, 8'hE0});
    rb = rd_count;
    run_draw(16'h0300, 4'd1, 8'd3, 8'd1, cyc);
    n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL unaligned_busy: got %0d cycles, required 7", cyc); end
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL unaligned_coll: got %b, required 0", collision); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL unaligned_writes: got %0d missing, required 0", exp_q.size()); exp_q.delete(); end
    n_checks++; if (rd_count - rb != 3) begin n_fail++; $display("FAIL unaligned_reads: got %0d, required 3", rd_count - rb); end
  endtask

  // Collision that comes only from the right-hand byte.
  task automatic test_right_collision();
    int cyc;
    clear_fb();
    mem[12'h300] = 8'hFF;
    mem[12'h109] = 8'h20;
    exp_q.push_back({12'h108, 8'h1F});
    exp_q.push_back({12'h109, 8'hC0});
    run_draw(16'h0300, 4'd1, 8'd3, 8'd1, cyc);
    n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL rcoll_busy: got %0d cycles, required 7", cyc); end
    n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL rcoll_flag: got %b, required 1", collision); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rcoll_writes: got %0d missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Runs after a collision=1 draw, so the clear on start is visible.
  task automatic test_zero_height();
    int cyc, rb;
    rb = rd_count;
    run_draw(16'h0300, 4'd0, 8'd5, 8'd5, cyc);
    n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL zero_busy: got %0d cycles, required 1", cyc); end
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL zero_coll: got %b, required 0", collision); end
    n_checks++; if (rd_count - rb != 0) begin n_fail++; $display("FAIL zero_reads: got %0d, required 0", rd_count - rb); end
  endtask

  // x=0xFE -> 62, y=0x3F -> 31, and the high address nibble is ignored.
  task automatic test_wrap();
    int cyc, exp_cyc;
    clear_fb();
    mem[12'h300] = 8'hF0;
    mem[12'h301] = 8'hF0;
`ifdef SPRITE_CLIP_EN
    exp_q.push_back({12'h1FF, 8'h03});
    exp_cyc = 5;
`else
    exp_q.push_back({12'h1FF, 8'h03});
    exp_q.push_back({12'h1F8, 8'hC0});
    exp_q.push_back({12'h107, 8'h03});
    exp_q.push_back({12'h100, 8'hC0});
    exp_cyc = 13;
`endif
    run_draw(16'hF300, 4'd2, 8'hFE, 8'h3F, cyc);
    n_checks++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL wrap_busy: got %0d cycles, required %0d", cyc, exp_cyc); end
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL wrap_coll: got %b, required 0", collision); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_writes: got %0d missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_ignore_draw();
    int cyc;
    clear_fb();
    mem[12'h300] = 8'hF0;
    mem[12'h301] = 8'hAA;
    exp_q.push_back({12'h100, 8'hF0});
    @(negedge clk);
    address = 16'h0300; sprite_height = 4'd1; x = 8'd0; y = 8'd0; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    cyc  = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 2) begin
        address = 16'h0301; x = 8'd8; draw = 1'b1;
      end else begin
        draw = 1'b0;
      end
      @(negedge clk);
    end
    draw = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL ignore_busy: got %0d cycles, required 5", cyc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_queued: got busy %b, required 0", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ignore_writes: got %0d missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Reset is raised in the WRITE_L cycle of row 2. That cycle's strobe is
  // already on the port when the reset edge arrives, so rows 0..2 are
  // committed on the left byte and nothing follows.
  task automatic test_reset_abort();
    int  cyc;
    logic reached;
    clear_fb();
    mem[12'h300] = 8'h01;
    mem[12'h301] = 8'h02;
    mem[12'h302] = 8'h04;
    mem[12'h303] = 8'h08;
    exp_q.push_back({12'h100, 8'h01});
    exp_q.push_back({12'h108, 8'h02});
    exp_q.push_back({12'h110, 8'h04});
    reached = 1'b0;
    @(negedge clk);
    address = 16'h0300; sprite_height = 4'd4; x = 8'd0; y = 8'd0; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    cyc  = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 12) begin
        reached = 1'b1;
        n_checks++; if (dbg_state !== 3'd4 || mem_write_enable !== 1'b1) begin
          n_fail++; $display("FAIL abort_in_write_l: got state %0d wr %b, required 4 1", dbg_state, mem_write_enable); end
        reset = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (reached !== 1'b1) begin n_fail++; $display("FAIL abort_reached: got %0d busy cycles, required 12", cyc); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy %b rd %b wr %b, required 0 0 0", busy, mem_read_enable, mem_write_enable); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_restart: got busy %b, required 0", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_writes: got %0d missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_aligned();
    test_collision();
    test_unaligned();
    test_right_collision();
    test_zero_height();
    test_wrap();
    test_ignore_draw();
    test_reset_abort();
    n_checks++;
    if (rw_overlap != 0) begin
      n_fail++;
      $display("FAIL rw_same_cycle: got %0d overlapping cycles, required 0", rw_overlap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
